mem_access_stage: RTL and testbench

- MIPS MEMORY (MEM) pipeline stage, the consumer of the EX/MEM latch fields: branch-decision logic, word-addressed data memory with configurable access latency and upstream stall handshake, and the MEM/WB pipeline register.
- Feeds PCSrc and the branch target back to FETCH and the register-write fields forward to WRITEBACK.

---
 rtl/mem_access_stage.sv | 108 ++++++++++
 tb/tb_mem_access_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: branch decision, word-addressed data memory, MEM/WB pipeline register.
// Latency: non-memory ops 1 cycle; loads/stores MEM_LAT cycles. Optional macro: MEM_ALIGN_CHECK_EN.
// Backpressure: stall holds EX/MEM inputs until the access completes; pcsrc ignores stall.
module mem_access_stage #(
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [1:0]  wb_ctl,
    input  logic [2:0]  m_ctl,
    input  logic [31:0] add_result,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2,
    input  logic [4:0]  dest_reg,
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic        stall,
    output logic [1:0]  wb_ctlout,
    output logic [31:0] read_data,
    output logic [31:0] alu_out,
    output logic [4:0]  dest_out,
    output logic        align_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  idx;
    logic           mem_op;
    logic           misalign;
    logic           bad;

    assign pcsrc         = in_valid & m_ctl[2] & zero;
    assign branch_target = add_result;

    assign idx    = alu_result[AW+1:2];
    assign mem_op = in_valid & (m_ctl[1] | m_ctl[0]);
    assign bad    = mem_op & misalign;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = |alu_result[1:0];
`else
    assign misalign = 1'b0;
`endif

    // In WAIT the access finishes on the edge where cnt reaches MEM_LAT-1.
    always_comb begin
        stall = 1'b0;
        if (state == IDLE)
            stall = mem_op && (MEM_LAT > 1);
        else
            stall = (cnt != LAT_M1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wb_ctlout <= 2'b00;
            read_data <= 32'd0;
            alu_out   <= 32'd0;
            dest_out  <= 5'd0;
        end else if (stall) begin
            wb_ctlout <= 2'b00;
            if (state == IDLE) begin
                state <= WAIT;
                cnt   <= 4'd1;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end else begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wb_ctlout <= (in_valid && !bad) ? wb_ctl : 2'b00;
            alu_out   <= alu_result;
            dest_out  <= dest_reg;
            // Read before the write lands, so a read+write returns the old word.
            if (bad)
                read_data <= 32'd0;
            else if (mem_op && m_ctl[1])
                read_data <= mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !stall && mem_op && m_ctl[0] && !misalign)
            mem[idx] <= rdata2;
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            align_err <= 1'b0;
        else
            align_err <= !stall && bad;
    end
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: one MEM_LAT=1 and one MEM_LAT=3 instance, scoreboard on MEM/WB.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  wb_ctl = 2'b00;
    logic [2:0]  m_ctl = 3'b000;
    logic [31:0] add_result = 32'd0;
    logic        zero = 1'b0;
    logic [31:0] alu_result = 32'd0;
    logic [31:0] rdata2 = 32'd0;
    logic [4:0]  dest_reg = 5'd0;

    logic        l1_pcsrc, l3_pcsrc, l1_stall, l3_stall, l1_al, l3_al;
    logic [31:0] l1_bt, l3_bt, l1_rd, l3_rd, l1_alu, l3_alu;
    logic [1:0]  l1_wb, l3_wb;
    logic [4:0]  l1_dest, l3_dest;

    logic        mon_sel = 1'b0;
    logic        m_pcsrc, m_stall, m_al;
    logic [31:0] m_bt, m_rd, m_alu;
    logic [1:0]  m_wb;
    logic [4:0]  m_dest;

    int n_vec  = 0;
    int n_miss = 0;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  dest;
        logic        al;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    mem_access_stage #(.DEPTH(256), .MEM_LAT(1)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .wb_ctl(wb_ctl), .m_ctl(m_ctl),
        .add_result(add_result), .zero(zero), .alu_result(alu_result), .rdata2(rdata2),
        .dest_reg(dest_reg), .pcsrc(l1_pcsrc), .branch_target(l1_bt), .stall(l1_stall),
        .wb_ctlout(l1_wb), .read_data(l1_rd), .alu_out(l1_alu), .dest_out(l1_dest),
        .align_err(l1_al)
    );

    mem_access_stage #(.DEPTH(256), .MEM_LAT(3)) u_l3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .wb_ctl(wb_ctl), .m_ctl(m_ctl),
        .add_result(add_result), .zero(zero), .alu_result(alu_result), .rdata2(rdata2),
        .dest_reg(dest_reg), .pcsrc(l3_pcsrc), .branch_target(l3_bt), .stall(l3_stall),
        .wb_ctlout(l3_wb), .read_data(l3_rd), .alu_out(l3_alu), .dest_out(l3_dest),
        .align_err(l3_al)
    );

    assign m_pcsrc = mon_sel ? l3_pcsrc : l1_pcsrc;
    assign m_bt    = mon_sel ? l3_bt    : l1_bt;
    assign m_stall = mon_sel ? l3_stall : l1_stall;
    assign m_wb    = mon_sel ? l3_wb    : l1_wb;
    assign m_rd    = mon_sel ? l3_rd    : l1_rd;
    assign m_alu   = mon_sel ? l3_alu   : l1_alu;
    assign m_dest  = mon_sel ? l3_dest  : l1_dest;
    assign m_al    = mon_sel ? l3_al    : l1_al;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: an instruction handshaken (in_valid & !stall) shows up on MEM/WB one cycle later.
    logic pend = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("wb_ctlout", {30'd0, m_wb}, {30'd0, e.wb});
                chk("read_data", m_rd, e.rd);
                chk("alu_out", m_alu, e.alu);
                chk("dest_out", {27'd0, m_dest}, {27'd0, e.dest});
                chk("align_err", {31'd0, m_al}, {31'd0, e.al});
            end
        end
        pend = in_valid && !m_stall && !rst;
    end

    task automatic drive(input logic v, input logic [1:0] wb, input logic [2:0] m,
                         input logic z, input logic [31:0] add, input logic [31:0] alu,
                         input logic [31:0] dat, input logic [4:0] dest);
        in_valid = v; wb_ctl = wb; m_ctl = m; zero = z;
        add_result = add; alu_result = alu; rdata2 = dat; dest_reg = dest;
    endtask

    // Called just after a rising edge; returns just after the completion edge.
    task automatic issue(input logic v, input logic [1:0] wb, input logic [2:0] m,
                         input logic z, input logic [31:0] add, input logic [31:0] alu,
                         input logic [31:0] dat, input logic [4:0] dest,
                         input logic exp_pc, input int exp_stalls, input exp_t e);
        int stalls = 0;
        drive(v, wb, m, z, add, alu, dat, dest);
        if (v) sbq.push_back(e);
        @(negedge clk);
        chk("pcsrc", {31'd0, m_pcsrc}, {31'd0, exp_pc});
        chk("branch_target", m_bt, add);
        while (m_stall && stalls < 20) begin
            stalls++;
            if (stalls >= 2) chk("wb_during_stall", {30'd0, m_wb}, 32'd0);
            @(negedge clk);
        end
        chk("stall_cycles", stalls, exp_stalls);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stall"}, {31'd0, m_stall}, 32'd0);
        chk({tag, "_wb"}, {30'd0, m_wb}, 32'd0);
        chk({tag, "_rd"}, m_rd, 32'd0);
        chk({tag, "_alu"}, m_alu, 32'd0);
        chk({tag, "_dest"}, {27'd0, m_dest}, 32'd0);
        chk({tag, "_align"}, {31'd0, m_al}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd7;
        // ---------------- MEM_LAT = 1 instance ----------------
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_l1");
        @(posedge clk); #1;

        issue(1, 2'b00, 3'b001, 0, 32'h0, 32'h10,  32'hDEADBEEF, 5'd0, 0, 0,
              '{wb:2'b00, rd:32'h0, alu:32'h10, dest:5'd0, al:1'b0});
        issue(1, 2'b11, 3'b010, 0, 32'h0, 32'h10,  32'h0, 5'd5, 0, 0,
              '{wb:2'b11, rd:32'hDEADBEEF, alu:32'h10, dest:5'd5, al:1'b0});
        issue(1, 2'b00, 3'b001, 0, 32'h0, 32'h400, 32'hA5A5A5A5, 5'd0, 0, 0,
              '{wb:2'b00, rd:32'hDEADBEEF, alu:32'h400, dest:5'd0, al:1'b0});
        issue(1, 2'b11, 3'b010, 0, 32'h0, 32'h0,   32'h0, 5'd7, 0, 0,
              '{wb:2'b11, rd:32'hA5A5A5A5, alu:32'h0, dest:5'd7, al:1'b0});
        issue(1, 2'b10, 3'b000, 0, 32'h0, 32'h55,  32'h0, 5'd9, 0, 0,
              '{wb:2'b10, rd:32'hA5A5A5A5, alu:32'h55, dest:5'd9, al:1'b0});

        // Bubble: wb_ctlout cleared, fields captured, read_data held.
        drive(0, 2'b11, 3'b010, 0, 32'h0, 32'h77, 32'h0, 5'd2);
        @(posedge clk);
        @(negedge clk);
        chk("bubble_wb", {30'd0, l1_wb}, 32'd0);
        chk("bubble_alu", l1_alu, 32'h77);
        chk("bubble_rd_hold", l1_rd, 32'hA5A5A5A5);
        @(posedge clk); #1;

        issue(1, 2'b10, 3'b001, 0, 32'h0, 32'h13, 32'h11111111, 5'd1, 0, 0,
              ALN ? '{wb:2'b00, rd:32'h0, alu:32'h13, dest:5'd1, al:1'b1}
                  : '{wb:2'b10, rd:32'hA5A5A5A5, alu:32'h13, dest:5'd1, al:1'b0});
        rd7 = ALN ? 32'hDEADBEEF : 32'h11111111;
        issue(1, 2'b11, 3'b010, 0, 32'h0, 32'h10, 32'h0, 5'd3, 0, 0,
              '{wb:2'b11, rd:rd7, alu:32'h10, dest:5'd3, al:1'b0});
        issue(1, 2'b11, 3'b011, 0, 32'h0, 32'h10, 32'h22222222, 5'd4, 0, 0,
              '{wb:2'b11, rd:rd7, alu:32'h10, dest:5'd4, al:1'b0});
        issue(1, 2'b11, 3'b010, 0, 32'h0, 32'h10, 32'h0, 5'd8, 0, 0,
              '{wb:2'b11, rd:32'h22222222, alu:32'h10, dest:5'd8, al:1'b0});

        // Branch decisions.
        issue(1, 2'b00, 3'b100, 1, 32'h00400040, 32'h0, 32'h0, 5'd0, 1, 0,
              '{wb:2'b00, rd:32'h22222222, alu:32'h0, dest:5'd0, al:1'b0});
        issue(1, 2'b00, 3'b100, 0, 32'h00400040, 32'h0, 32'h0, 5'd0, 0, 0,
              '{wb:2'b00, rd:32'h22222222, alu:32'h0, dest:5'd0, al:1'b0});
        issue(0, 2'b00, 3'b100, 1, 32'h00400040, 32'h0, 32'h0, 5'd0, 0, 0,
              '{wb:2'b00, rd:32'h0, alu:32'h0, dest:5'd0, al:1'b0});
        drive(0, 2'b00, 3'b000, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        repeat (2) @(posedge clk);

        // ---------------- MEM_LAT = 3 instance ----------------
        #1 mon_sel = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_l3");
        @(posedge clk); #1;

        issue(1, 2'b00, 3'b001, 0, 32'h0, 32'h20, 32'h12345678, 5'd0, 0, 2,
              '{wb:2'b00, rd:32'h0, alu:32'h20, dest:5'd0, al:1'b0});
        issue(1, 2'b11, 3'b010, 0, 32'h0, 32'h20, 32'h0, 5'd6, 0, 2,
              '{wb:2'b11, rd:32'h12345678, alu:32'h20, dest:5'd6, al:1'b0});

        // Store aborted by reset in its second stall cycle.
        drive(1, 2'b00, 3'b001, 0, 32'h0, 32'h20, 32'hCAFEF00D, 5'd0);
        @(negedge clk);
        chk("abort_stall_first", {31'd0, l3_stall}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 2'b00, 3'b000, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        check_reset_outputs("abort");
        @(posedge clk); #1;

        issue(1, 2'b11, 3'b010, 0, 32'h0, 32'h20, 32'h0, 5'd10, 0, 2,
              '{wb:2'b11, rd:32'h12345678, alu:32'h20, dest:5'd10, al:1'b0});
        drive(0, 2'b00, 3'b000, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", sbq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
